banco_write_arbiter: RTL

//  Shares the single write port of Banco_Registros (RegWrite/WriteRegister/WriteData) among NREQ

---
 rtl/banco_pkg.sv | 10 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/banco_write_arbiter.sv | 68 ++++++
 3 files changed

// File: rtl/banco_pkg.sv
// banco_pkg: shared register-bank constants and a modular-add helper for round-robin indexing.
package banco_pkg;
    localparam int REG_AW = 5;
    localparam int REG_DW = 32;
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    function automatic int wrap_add(input int base, input int k, input int n);
        return (base + k >= n) ? base + k - n : base + k;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first asserted request at or after ptr (wrapping); pure combinational.
module rr_arbiter
    import banco_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int PW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   idx,
    output logic            found
);
    logic [PW-1:0] j;

    // Scan farthest-first so the slot closest to ptr is the last, winning, assignment.
    always_comb begin
        grant = '0;
        idx = '0;
        found = 1'b0;
        j = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = PW'(wrap_add(int'(ptr), k, NREQ));
            if (req[j]) begin
                grant = NREQ'(1) << j;
                idx = j;
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/banco_write_arbiter.sv
// banco_write_arbiter: round-robin share of the register-bank write port with one registered
// output stage, $zero suppression and a pending-write bitmap for hazard checks.
module banco_write_arbiter
    import banco_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW = REG_AW,
    parameter int DW = REG_DW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hold,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic               RegWrite,
    output logic [AW-1:0]      WriteRegister,
    output logic [DW-1:0]      WriteData,
    output logic [2**AW-1:0]   pend_mask
);
    localparam int PW = $clog2(NREQ);

    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   idx;
    logic            found;
    logic            arb_en;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;

    assign arb_en = rst_n & ~hold;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req   (req_valid & {NREQ{arb_en}}),
        .ptr   (rr_ptr),
        .grant (req_ready),
        .idx   (idx),
        .found (found)
    );

    assign sel_addr = req_addr[idx*AW +: AW];
    assign sel_data = req_data[idx*DW +: DW];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            RegWrite <= 1'b0;
            WriteRegister <= '0;
            WriteData <= '0;
            rr_ptr <= '0;
        end else begin
            RegWrite <= found && (sel_addr != AW'(REG_ZERO));
            if (found) begin
                WriteRegister <= sel_addr;
                WriteData <= sel_data;
                rr_ptr <= PW'(wrap_add(int'(idx), 1, NREQ));
            end
        end
    end

    // The output-stage term is masked in reset so the bitmap shows only live requests then.
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < NREQ; i++)
            if (req_valid[i]) pend_mask[req_addr[i*AW +: AW]] = 1'b1;
        if (rst_n && RegWrite) pend_mask[WriteRegister] = 1'b1;
        pend_mask[0] = 1'b0;
    end
endmodule
